// File: rtl/arm_control_unit.sv
// arm_control_unit: microprogrammed fetch/decode/execute sequencer driving the 45-bit DataPath control word.
// Optional BRANCH_LINK_EN adds the S31 link step so BL writes the return address to R14.
module arm_control_unit #(
    parameter int STATE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mfc,
    input  logic [31:0] cu_in,
    input  logic [3:0]  flags,
    output logic [44:0] cu_out
);
    typedef enum logic [STATE_W-1:0] {
        S0  = STATE_W'(0),
        S1  = STATE_W'(1),
        S2  = STATE_W'(2),
        S3  = STATE_W'(3),
        S4  = STATE_W'(4),
        S5  = STATE_W'(5),
        S10 = STATE_W'(10),
        S11 = STATE_W'(11),
        S20 = STATE_W'(20),
        S21 = STATE_W'(21),
        S22 = STATE_W'(22),
        S23 = STATE_W'(23),
        S30 = STATE_W'(30)
`ifdef BRANCH_LINK_EN
        , S31 = STATE_W'(31)
`endif
    } state_t;

    state_t state_q, state_d;
    logic       cond_ok;
    logic       rf_en, shf_en, sr_en, ms, sext_en, mb, mc, md, r_w, mem_en;
    logic       mfa, ir_en, mar_en, mdr_en, sext2;
    logic [3:0] wr, ra, rb, op;
    logic [1:0] dtype, imm_sel;
    logic       unused_bits;

    assign unused_bits = ^cu_in[11:4];

    always_comb begin
        case (cu_in[31:28])
            4'd0:    cond_ok = flags[2];
            4'd1:    cond_ok = !flags[2];
            4'd2:    cond_ok = flags[1];
            4'd3:    cond_ok = !flags[1];
            4'd4:    cond_ok = flags[3];
            4'd5:    cond_ok = !flags[3];
            4'd6:    cond_ok = flags[0];
            4'd7:    cond_ok = !flags[0];
            4'd8:    cond_ok = flags[1] && !flags[2];
            4'd9:    cond_ok = !flags[1] || flags[2];
            4'd10:   cond_ok = flags[3] == flags[0];
            4'd11:   cond_ok = flags[3] != flags[0];
            4'd12:   cond_ok = !flags[2] && (flags[3] == flags[0]);
            4'd13:   cond_ok = flags[2] || (flags[3] != flags[0]);
            4'd14:   cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rf_en = 1'b0; wr = 4'd0; ra = 4'd0; rb = 4'd0; op = 4'd0;
        shf_en = 1'b0; sr_en = 1'b0; ms = 1'b0; sext_en = 1'b0;
        mb = 1'b0; mc = 1'b0; md = 1'b0; r_w = 1'b0; mem_en = 1'b1;
        dtype = 2'b00; mfa = 1'b0; ir_en = 1'b0; mar_en = 1'b0;
        mdr_en = 1'b0; sext2 = 1'b0; imm_sel = 2'b00;
        case (state_q)
            S0: state_d = S1;
            S1: begin
                mar_en = 1'b1; ra = 4'd15; op = 4'b1101;
                state_d = S2;
            end
            S2: begin
                rf_en = 1'b1; wr = 4'd15; ra = 4'd15; op = 4'b0100; mb = 1'b1;
                mem_en = 1'b0; mfa = 1'b1; dtype = 2'b10;
                state_d = S3;
            end
            S3: begin
                mem_en = 1'b0; mfa = 1'b1; mdr_en = 1'b1; dtype = 2'b10;
                state_d = mfc ? S4 : S3;
            end
            S4: begin
                ir_en = 1'b1;
                state_d = S5;
            end
            S5: begin
                casez (cu_in[27:25])
                    3'b000:  state_d = S10;
                    3'b001:  state_d = S11;
                    3'b01?:  state_d = S20;
`ifdef BRANCH_LINK_EN
                    3'b101:  state_d = cu_in[24] ? S31 : S30;
`else
                    3'b101:  state_d = S30;
`endif
                    default: state_d = S1;
                endcase
                if (!cond_ok) state_d = S1;
            end
            S10, S11: begin
                wr = cu_in[15:12]; ra = cu_in[19:16]; rb = cu_in[3:0]; op = cu_in[24:21];
                shf_en = 1'b1; sr_en = cu_in[20];
                rf_en = cu_in[24:23] != 2'b10;
                imm_sel = (state_q == S11) ? 2'b01 : 2'b00;
                mb = state_q == S11;
                state_d = S1;
            end
            S20: begin
                mar_en = 1'b1; ra = cu_in[19:16];
                op = cu_in[23] ? 4'b0100 : 4'b0010;
                sext_en = !cu_in[25];
                state_d = cu_in[20] ? S22 : S21;
            end
            S21: begin
                mdr_en = 1'b1; rb = cu_in[15:12]; mc = 1'b1;
                state_d = S22;
            end
            S22: begin
                mem_en = 1'b0; mfa = 1'b1; r_w = !cu_in[20];
                dtype = cu_in[22] ? 2'b00 : 2'b10;
                mdr_en = cu_in[20];
                state_d = mfc ? (cu_in[20] ? S23 : S1) : S22;
            end
            S23: begin
                rf_en = 1'b1; wr = cu_in[15:12]; md = 1'b1;
                state_d = S1;
            end
            S30: begin
                rf_en = 1'b1; wr = 4'd15; ra = 4'd15; op = 4'b0100; sext2 = 1'b1; ms = 1'b1;
                state_d = S1;
            end
`ifdef BRANCH_LINK_EN
            S31: begin
                rf_en = 1'b1; wr = 4'd14; ra = 4'd15; op = 4'b1101;
                state_d = S30;
            end
`endif
            default: state_d = S0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S0;
        else state_q <= state_d;
    end

    // Ma, Me, Mf, Mg, Ml, Mo and dwp are never asserted by this microprogram.
    assign cu_out = {rf_en, 1'b0, wr, ra, rb, op, 2'b00, shf_en, sr_en, ms, sext_en,
                     mb, mc, md, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, r_w, mem_en, dtype,
                     1'b0, mfa, ir_en, mar_en, mdr_en, sext2, imm_sel};
endmodule

// File: tb/tb_arm_control_unit.sv
// tb_arm_control_unit: scoreboard bench; an instruction-level model expands each instruction into its expected control-word sequence.
module tb_arm_control_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mfc = 1'b0;
    logic [31:0] cu_in = 32'd0;
    logic [3:0]  flags = 4'd0;
    logic [44:0] cu_out;

    arm_control_unit dut (
        .clk(clk), .reset(reset), .mfc(mfc), .cu_in(cu_in), .flags(flags), .cu_out(cu_out)
    );

    always #5 clk = ~clk;

    localparam int RFEN = 44, WR = 39, RA = 35, RB = 31, OP = 27, SHF = 24, SRE = 23;
    localparam int MS = 22, SEXT = 21, MB = 20, MC = 19, MD = 18, RW = 11, MEM = 10;
    localparam int DT = 8, MFA = 6, IR = 5, MAR = 4, MDR = 3, SEXT2 = 2, IMM = 0;

    typedef struct {
        logic [44:0] w;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;

    function automatic logic [44:0] b(input int n);
        return 45'd1 << n;
    endfunction

    function automatic logic [44:0] f(input logic [3:0] v, input int lo);
        return 45'(v) << lo;
    endfunction

    function automatic bit cond_model(input logic [3:0] c, input logic [3:0] fl);
        bit n, z, cf, v;
        bit base[7];
        n = fl[3]; z = fl[2]; cf = fl[1]; v = fl[0];
        if (c == 4'd15) return 1'b0;
        if (c == 4'd14) return 1'b1;
        base = '{z, cf, n, v, cf && !z, n == v, !z && (n == v)};
        return base[int'(c) >> 1] ^ c[0];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            compared++;
            if (cu_out !== e.w) begin
                mismatched++;
                $display("FAIL %s: cu_out=%h expected %h (t=%0t)", e.tag, cu_out, e.w, $time);
            end
        end
    end

    task automatic cyc(input logic [44:0] w, input string tag, input logic m,
                       input logic [31:0] ci, input logic [3:0] fl);
        mfc = m; cu_in = ci; flags = fl;
        q.push_back('{w, tag});
        @(posedge clk);
        #1;
    endtask

    task automatic reset_seq();
        reset = 1'b1;
        cyc(b(MEM), "reset", 1'($urandom), $urandom, 4'($urandom));
        reset = 1'b0;
        cyc(b(MEM), "S0", 1'($urandom), $urandom, 4'($urandom));
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic [3:0] fl,
                             input int fw, input int mw, input int abort);
        logic [44:0] w, s3, ls;
        logic [3:0]  rd, rn, rm, opc;
        bit          ld;
        rd = ins[15:12]; rn = ins[19:16]; rm = ins[3:0]; opc = ins[24:21]; ld = ins[20];
        cyc(b(MEM) | b(MAR) | f(15, RA) | f(4'b1101, OP), "S1", 1'($urandom), $urandom, 4'($urandom));
        cyc(b(RFEN) | f(15, WR) | f(15, RA) | f(4'b0100, OP) | b(MB) | b(MFA) | f(2, DT),
            "S2", 1'($urandom), $urandom, 4'($urandom));
        s3 = b(MFA) | b(MDR) | f(2, DT);
        if (abort == 1) begin
            cyc(s3, "S3", 1'b0, $urandom, 4'($urandom));
            reset_seq();
            return;
        end
        for (int i = 0; i < fw; i++) cyc(s3, "S3 wait", 1'b0, $urandom, 4'($urandom));
        cyc(s3, "S3", 1'b1, $urandom, 4'($urandom));
        cyc(b(MEM) | b(IR), "S4", 1'($urandom), ins, 4'($urandom));
        cyc(b(MEM), "S5", 1'($urandom), ins, fl);
        if (!cond_model(ins[31:28], fl)) return;
        case (ins[27:25])
            3'b000, 3'b001: begin
                w = b(MEM) | f(rd, WR) | f(rn, RA) | f(rm, RB) | f(opc, OP) | b(SHF);
                if (ins[20]) w |= b(SRE);
                if (opc[3:2] != 2'b10) w |= b(RFEN);
                if (ins[25]) w |= f(1, IMM) | b(MB);
                cyc(w, ins[25] ? "S11" : "S10", 1'($urandom), ins, 4'($urandom));
            end
            3'b010, 3'b011: begin
                w = b(MEM) | b(MAR) | f(rn, RA) | f(ins[23] ? 4'b0100 : 4'b0010, OP);
                if (!ins[25]) w |= b(SEXT);
                cyc(w, "S20", 1'($urandom), ins, 4'($urandom));
                if (!ld) cyc(b(MEM) | b(MDR) | f(rd, RB) | b(MC), "S21", 1'($urandom), ins, 4'($urandom));
                ls = b(MFA) | (ld ? b(MDR) : b(RW)) | (ins[22] ? 45'd0 : f(2, DT));
                if (abort == 2) begin
                    cyc(ls, "S22", 1'b0, ins, 4'($urandom));
                    reset_seq();
                    return;
                end
                for (int i = 0; i < mw; i++) cyc(ls, "S22 wait", 1'b0, ins, 4'($urandom));
                cyc(ls, "S22", 1'b1, ins, 4'($urandom));
                if (ld) cyc(b(MEM) | b(RFEN) | f(rd, WR) | b(MD), "S23", 1'($urandom), ins, 4'($urandom));
            end
            3'b101: begin
`ifdef BRANCH_LINK_EN
                if (ins[24])
                    cyc(b(MEM) | b(RFEN) | f(14, WR) | f(15, RA) | f(4'b1101, OP), "S31",
                        1'($urandom), ins, 4'($urandom));
`endif
                cyc(b(MEM) | b(RFEN) | f(15, WR) | f(15, RA) | f(4'b0100, OP) | b(SEXT2) | b(MS),
                    "S30", 1'($urandom), ins, 4'($urandom));
            end
            default: ;
        endcase
    endtask

    initial begin
        @(posedge clk);
        #1;
        reset_seq();
        run_instr(32'hE0810002, 4'($urandom), 3, 0, 0);
        run_instr(32'h03510000, 4'b0000, 0, 0, 0);
        run_instr(32'h03510000, 4'b0100, 0, 0, 0);
        run_instr(32'hE5912004, 4'($urandom), 1, 2, 0);
        run_instr(32'hE5C12000, 4'($urandom), 0, 1, 0);
        run_instr(32'hEBFFFFFE, 4'($urandom), 0, 0, 0);
        run_instr(32'hEAFFFFFE, 4'($urandom), 0, 0, 0);
        run_instr(32'hF0810002, 4'($urandom), 0, 0, 0);
        run_instr(32'hE5912004, 4'($urandom), 2, 0, 1);
        run_instr(32'hE5912004, 4'($urandom), 0, 3, 2);
        run_instr(32'hE5C12000, 4'($urandom), 0, 3, 2);
        for (int k = 0; k < 300; k++)
            run_instr($urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 19) == 0) ? $urandom_range(1, 2) : 0);
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
